// File: rtl/duoseg_avalon_writer_if.sv
// Value stream plus Avalon-MM write channel between the duoseg writer and its neighbours.
// The master modport is the writer's view; the slave modport is the producer/display side.
interface duoseg_avalon_writer_if;
    logic [7:0]  value_in;
    logic        value_valid;
    logic        value_ready;
    logic [1:0]  master_address;
    logic        master_write;
    logic [15:0] master_writedata;
    logic [1:0]  master_byteenable;
    logic        master_waitrequest;

    modport master (
        input  value_in,
        input  value_valid,
        input  master_waitrequest,
        output value_ready,
        output master_address,
        output master_write,
        output master_writedata,
        output master_byteenable
    );

    modport slave (
        output value_in,
        output value_valid,
        output master_waitrequest,
        input  value_ready,
        input  master_address,
        input  master_write,
        input  master_writedata,
        input  master_byteenable
    );
endinterface

// File: rtl/duoseg_avalon_writer.sv
// Avalon-MM master for the dual seven-segment display register: takes 8-bit values from a
// valid/ready stream, hex-encodes both nibbles and issues one 16-bit write per value.
module duoseg_avalon_writer #(
    parameter logic [1:0] SEG_ADDR   = 2'd0,
    parameter bit         ACTIVE_LOW = 1'b1,
    parameter bit         SKIP_SAME  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    duoseg_avalon_writer_if.master bus,
    output logic                   busy,
    output logic [15:0]            write_count
);
    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        pend_valid_q, pend_valid_d;
    logic        last_valid_q, last_valid_d;
    logic        write_q, write_d;
    logic [1:0]  be_q, be_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  pend_q, pend_d;
    logic [7:0]  inflight_q, inflight_d;
    logic [7:0]  last_q, last_d;
    logic        accept;

    // Segment order g,f,e,d,c,b,a from bit 6 down to bit 0.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
        return seg;
    endfunction

    function automatic logic [15:0] encode(input logic [7:0] v);
        logic [6:0] hi;
        logic [6:0] lo;
        hi = hex_to_seg(v[7:4]);
        lo = hex_to_seg(v[3:0]);
        if (ACTIVE_LOW) begin
            hi = ~hi;
            lo = ~lo;
        end
        return {1'b0, hi, 1'b0, lo};
    endfunction

    assign accept = bus.value_valid & ~pend_valid_q;

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        last_valid_d = last_valid_q;
        write_d      = write_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        count_d      = count_q;
        pend_d       = pend_q;
        inflight_d   = inflight_q;
        last_d       = last_q;

        case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    pend_valid_d = 1'b0;
                    if (!(SKIP_SAME && last_valid_q && (pend_q == last_q))) begin
                        wdata_d    = encode(pend_q);
                        write_d    = 1'b1;
                        be_d       = 2'b11;
                        inflight_d = pend_q;
                        state_d    = WRITE;
                    end
                end
            end
            WRITE: begin
                if (!bus.master_waitrequest) begin
                    write_d      = 1'b0;
                    be_d         = 2'b00;
                    last_d       = inflight_q;
                    last_valid_d = 1'b1;
                    count_d      = count_q + 16'd1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The pending slot is only writable while empty, so this never collides with a launch.
        if (accept) begin
            pend_d       = bus.value_in;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pend_valid_q <= 1'b0;
            last_valid_q <= 1'b0;
            write_q      <= 1'b0;
            be_q         <= 2'b00;
            wdata_q      <= 16'h0000;
            count_q      <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            last_valid_q <= last_valid_d;
            write_q      <= write_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            count_q      <= count_d;
        end
    end

    // Value holders are qualified by the valid flags above and need no reset.
    always_ff @(posedge clk) begin
        pend_q     <= pend_d;
        inflight_q <= inflight_d;
        last_q     <= last_d;
    end

    assign bus.value_ready       = ~pend_valid_q;
    assign bus.master_address    = SEG_ADDR;
    assign bus.master_write      = write_q;
    assign bus.master_writedata  = wdata_q;
    assign bus.master_byteenable = be_q;
    assign busy                  = write_q | pend_valid_q;
    assign write_count           = count_q;
endmodule

// File: tb/tb_duoseg_avalon_writer.sv
// Bench for duoseg_avalon_writer: an active-high and an active-low instance share one stimulus
// stream; completed writes are compared with a reference model of the display rules.
module tb_duoseg_avalon_writer;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] v_value;
    logic       v_valid;
    logic       wreq;
    logic       busy0, busy1;
    logic [15:0] cnt0, cnt1;

    always #5 clk = ~clk;

    duoseg_avalon_writer_if if0 ();
    duoseg_avalon_writer_if if1 ();

    assign if0.value_in           = v_value;
    assign if0.value_valid        = v_valid;
    assign if0.master_waitrequest = wreq;
    assign if1.value_in           = v_value;
    assign if1.value_valid        = v_valid;
    assign if1.master_waitrequest = wreq;

    duoseg_avalon_writer #(.SEG_ADDR(2'd0), .ACTIVE_LOW(1'b0), .SKIP_SAME(1'b1)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0), .busy(busy0), .write_count(cnt0));
    duoseg_avalon_writer #(.SEG_ADDR(2'd0), .ACTIVE_LOW(1'b1), .SKIP_SAME(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1), .busy(busy1), .write_count(cnt1));

    localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int checks = 0;
    int errors = 0;

    // Reference model: the write sequence is the accepted sequence minus repeats of the last written value.
    logic [7:0] exp_q [$];
    logic       mdl_last_valid = 1'b0;
    logic [7:0] mdl_last = 8'h00;
    int         exp_count = 0;

    function automatic logic [15:0] ref_enc(input logic [7:0] v, input bit al);
        logic [6:0] h;
        logic [6:0] l;
        h = SEG_TAB[v[7:4]];
        l = SEG_TAB[v[3:0]];
        if (al) begin
            h = ~h;
            l = ~l;
        end
        return {1'b0, h, 1'b0, l};
    endfunction

    // Observation queues filled at the falling edge.
    int          cyc = 0;
    logic [7:0]  acc_q [$];
    int          acc_cyc [$];
    logic [15:0] obs_d0 [$];
    logic [15:0] obs_d1 [$];
    int          obs_launch [$];
    int          obs_done [$];
    int          stab_err = 0;
    int          bus_err = 0;
    int          sync_err = 0;
    logic        prev_stall = 1'b0;
    logic        prev_write = 1'b0;
    logic [15:0] prev_data = 16'h0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!reset_n) begin
            prev_stall <= 1'b0;
            prev_write <= 1'b0;
        end else begin
            if (v_valid && if0.value_ready) begin
                acc_q.push_back(v_value);
                acc_cyc.push_back(cyc);
            end
            if (if0.master_write && !prev_write) obs_launch.push_back(cyc);
            if (if0.master_write && !wreq) begin
                obs_d0.push_back(if0.master_writedata);
                obs_d1.push_back(if1.master_writedata);
                obs_done.push_back(cyc);
            end
            if (prev_stall && (!if0.master_write || if0.master_writedata !== prev_data ||
                               if0.master_byteenable !== 2'b11))
                stab_err <= stab_err + 1;
            if (if0.master_byteenable !== (if0.master_write ? 2'b11 : 2'b00) ||
                if0.master_address !== 2'd0 || busy0 !== (if0.master_write | ~if0.value_ready))
                bus_err <= bus_err + 1;
            if (if1.master_write !== if0.master_write || if1.value_ready !== if0.value_ready ||
                cnt1 !== cnt0 || busy1 !== busy0)
                sync_err <= sync_err + 1;
            prev_stall <= if0.master_write && wreq;
            prev_write <= if0.master_write;
            prev_data  <= if0.master_writedata;
        end
    end

    task automatic model_run();
        exp_q.delete();
        foreach (acc_q[i]) begin
            if (!(mdl_last_valid && acc_q[i] == mdl_last)) begin
                exp_q.push_back(acc_q[i]);
                mdl_last       = acc_q[i];
                mdl_last_valid = 1'b1;
                exp_count++;
            end
        end
    endtask

    task automatic clear_obs();
        acc_q.delete();
        acc_cyc.delete();
        obs_d0.delete();
        obs_d1.delete();
        obs_launch.delete();
        obs_done.delete();
    endtask

    // Present one value and hold it until accepted; returns just after the accepting edge.
    task automatic offer(input logic [7:0] v);
        bit took = 1'b0;
        v_value = v;
        v_valid = 1'b1;
        for (int i = 0; i < 60 && !took; i++) begin
            @(negedge clk);
            took = if0.value_ready;
            @(posedge clk);
            #1;
        end
        v_valid = 1'b0;
        checks++;
        if (!took) begin
            errors++;
            $display("FAIL offer_timeout: value %h not accepted, ready=%b expected 1", v, if0.value_ready);
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = !busy0 && !if0.master_write;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: busy=%b expected 0", busy0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        v_valid = 1'b0;
        v_value = 8'h00;
        wreq    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({if0.master_write, if0.master_byteenable, busy0} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: write/be/busy=%b expected 0000",
                     {if0.master_write, if0.master_byteenable, busy0});
        end
        checks++;
        if (if0.master_writedata !== 16'h0 || if1.master_writedata !== 16'h0 || cnt0 !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: data=%h/%h count=%h expected 0", if0.master_writedata,
                     if1.master_writedata, cnt0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (if0.value_ready !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b expected 1 0", if0.value_ready, busy0);
        end
        @(posedge clk);
        #1;
        clear_obs();
    endtask

    task automatic test_reset_mid_write();
        bit seen = 1'b0;
        wreq = 1'b1;
        offer(8'h55);
        offer(8'h66);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = if0.master_write;
        end
        checks++;
        if (!seen || if0.value_ready !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_setup: write=%b ready=%b busy=%b expected 1 0 1", if0.master_write,
                     if0.value_ready, busy0);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (if0.master_write !== 1'b0 || if1.master_write !== 1'b0 || if0.master_byteenable !== 2'b00) begin
            errors++;
            $display("FAIL midrst_write: write=%b/%b be=%b expected 0/0 00", if0.master_write,
                     if1.master_write, if0.master_byteenable);
        end
        checks++;
        if (if0.master_writedata !== 16'h0 || cnt0 !== 16'h0 || busy0 !== 1'b0 || if0.value_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state: data=%h count=%h busy=%b ready=%b expected 0 0 0 1",
                     if0.master_writedata, cnt0, busy0, if0.value_ready);
        end
        wreq = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (if0.value_ready !== 1'b1 || busy0 !== 1'b0 || if0.master_write !== 1'b0) begin
            errors++;
            $display("FAIL midrst_release: ready=%b busy=%b write=%b expected 1 0 0", if0.value_ready,
                     busy0, if0.master_write);
        end
        @(posedge clk);
        #1;
        clear_obs();
        mdl_last_valid = 1'b0;
        exp_count      = 0;
    endtask

    task automatic test_single();
        wreq = 1'b0;
        offer(8'h3A);
        drain();
        model_run();
        checks++;
        if (obs_d0.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL single_nwrites: got %0d expected %0d", obs_d0.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_d0.size()) begin
            checks++;
            if (obs_d0[i] !== ref_enc(exp_q[i], 1'b0) || obs_d1[i] !== ref_enc(exp_q[i], 1'b1)) begin
                errors++;
                $display("FAIL single_data: got %h/%h expected %h/%h", obs_d0[i], obs_d1[i],
                         ref_enc(exp_q[i], 1'b0), ref_enc(exp_q[i], 1'b1));
            end
        end
        if (obs_done.size() > 0 && obs_launch.size() > 0 && acc_cyc.size() > 0) begin
            checks++;
            if (obs_done[0] - obs_launch[0] !== 0 || obs_launch[0] - acc_cyc[0] !== 2) begin
                errors++;
                $display("FAIL single_timing: high=%0d latency=%0d expected 1 2",
                         obs_done[0] - obs_launch[0] + 1, obs_launch[0] - acc_cyc[0]);
            end
        end
        checks++;
        if (cnt0 !== 16'(exp_count)) begin
            errors++;
            $display("FAIL single_count: got %0d expected %0d", cnt0, exp_count);
        end
        clear_obs();
    endtask

    task automatic test_skip();
        offer(8'h3A);
        drain();
        model_run();
        checks++;
        if (obs_d0.size() !== exp_q.size() || cnt0 !== 16'(exp_count)) begin
            errors++;
            $display("FAIL skip_repeat: writes=%0d count=%0d expected %0d %0d", obs_d0.size(), cnt0,
                     exp_q.size(), exp_count);
        end
        clear_obs();
        offer(8'h3B);
        drain();
        model_run();
        checks++;
        if (obs_d0.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL skip_next_nwrites: got %0d expected %0d", obs_d0.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_d0.size()) begin
            checks++;
            if (obs_d0[i] !== ref_enc(exp_q[i], 1'b0) || obs_d1[i] !== ref_enc(exp_q[i], 1'b1)) begin
                errors++;
                $display("FAIL skip_next_data: got %h/%h expected %h/%h", obs_d0[i], obs_d1[i],
                         ref_enc(exp_q[i], 1'b0), ref_enc(exp_q[i], 1'b1));
            end
        end
        checks++;
        if (cnt0 !== 16'(exp_count)) begin
            errors++;
            $display("FAIL skip_count: got %0d expected %0d", cnt0, exp_count);
        end
        clear_obs();
    endtask

    task automatic test_waitreq();
        bit seen = 1'b0;
        wreq = 1'b1;
        offer(8'h3A);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = if0.master_write;
        end
        repeat (3) @(posedge clk);
        #1 wreq = 1'b0;
        drain();
        model_run();
        checks++;
        if (obs_d0.size() !== exp_q.size() || obs_d0.size() !== obs_launch.size()) begin
            errors++;
            $display("FAIL wait_nwrites: got %0d (launches %0d) expected %0d", obs_d0.size(),
                     obs_launch.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_d0.size()) begin
            checks++;
            if (obs_d0[i] !== ref_enc(exp_q[i], 1'b0) || obs_d1[i] !== ref_enc(exp_q[i], 1'b1)) begin
                errors++;
                $display("FAIL wait_data: got %h/%h expected %h/%h", obs_d0[i], obs_d1[i],
                         ref_enc(exp_q[i], 1'b0), ref_enc(exp_q[i], 1'b1));
            end
        end
        if (obs_done.size() > 0 && obs_launch.size() > 0) begin
            checks++;
            if (obs_done[0] - obs_launch[0] + 1 !== 4) begin
                errors++;
                $display("FAIL wait_duration: write high %0d cycles expected 4",
                         obs_done[0] - obs_launch[0] + 1);
            end
        end
        checks++;
        if (stab_err !== 0 || bus_err !== 0) begin
            errors++;
            $display("FAIL wait_stable: stability errs %0d bus errs %0d expected 0", stab_err, bus_err);
        end
        checks++;
        if (cnt0 !== 16'(exp_count)) begin
            errors++;
            $display("FAIL wait_count: got %0d expected %0d", cnt0, exp_count);
        end
        clear_obs();
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3];
        int idx = 0;
        bit took;
        vals[0] = 8'h10;
        vals[1] = 8'h20;
        vals[2] = 8'h30;
        wreq    = 1'b1;
        v_value = vals[0];
        v_valid = 1'b1;
        for (int c = 0; c < 60 && idx < 3; c++) begin
            @(negedge clk);
            took = if0.value_ready;
            if (c == 6) begin
                checks++;
                if (idx !== 2 || if0.value_ready !== 1'b0 || busy0 !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_stall: accepted=%0d ready=%b busy=%b expected 2 0 1", idx,
                             if0.value_ready, busy0);
                end
            end
            @(posedge clk);
            #1;
            if (took) begin
                idx++;
                if (idx < 3) v_value = vals[idx];
                else v_valid = 1'b0;
            end
            if (c == 8) wreq = 1'b0;
        end
        v_valid = 1'b0;
        wreq    = 1'b0;
        drain();
        model_run();
        checks++;
        if (obs_d0.size() !== exp_q.size() || obs_launch.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL b2b_nwrites: got %0d (launches %0d) expected %0d", obs_d0.size(),
                     obs_launch.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_d0.size()) begin
            checks++;
            if (obs_d0[i] !== ref_enc(exp_q[i], 1'b0) || obs_d1[i] !== ref_enc(exp_q[i], 1'b1)) begin
                errors++;
                $display("FAIL b2b_data[%0d]: got %h/%h expected %h/%h", i, obs_d0[i], obs_d1[i],
                         ref_enc(exp_q[i], 1'b0), ref_enc(exp_q[i], 1'b1));
            end
        end
        for (int k = 0; k + 1 < obs_launch.size() && k < obs_done.size(); k++) begin
            checks++;
            if (obs_launch[k+1] - obs_done[k] !== 2) begin
                errors++;
                $display("FAIL b2b_gap[%0d]: idle gap %0d cycles expected 1", k,
                         obs_launch[k+1] - obs_done[k] - 1);
            end
        end
        checks++;
        if (cnt0 !== 16'(exp_count)) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected %0d", cnt0, exp_count);
        end
        clear_obs();
    endtask

    task automatic test_active_low();
        wreq = 1'b0;
        offer(8'h08);
        drain();
        model_run();
        checks++;
        if (obs_d1.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL al_nwrites: got %0d expected %0d", obs_d1.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_d1.size()) begin
            checks++;
            if (obs_d1[i] !== ref_enc(exp_q[i], 1'b1) || obs_d0[i] !== ref_enc(exp_q[i], 1'b0)) begin
                errors++;
                $display("FAIL al_data: got %h/%h expected %h/%h", obs_d1[i], obs_d0[i],
                         ref_enc(exp_q[i], 1'b1), ref_enc(exp_q[i], 1'b0));
            end
        end
        clear_obs();
    endtask

    task automatic test_random();
        bit took;
        int sent = 0;
        logic [7:0] lastv = 8'h3A;
        v_valid = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            took = v_valid && if0.value_ready;
            @(posedge clk);
            #1;
            wreq = ($urandom_range(0, 2) == 0);
            if (took || !v_valid) begin
                if (sent < 80 && $urandom_range(0, 3) != 0) begin
                    case ($urandom_range(0, 3))
                        0:       v_value = lastv;
                        1:       v_value = 8'h3A;
                        default: v_value = 8'($urandom);
                    endcase
                    lastv   = v_value;
                    v_valid = 1'b1;
                    sent++;
                end else begin
                    v_valid = 1'b0;
                end
            end
        end
        v_valid = 1'b0;
        wreq    = 1'b0;
        drain();
        model_run();
        checks++;
        if (obs_d0.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rand_nwrites: got %0d expected %0d", obs_d0.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_d0.size()) begin
            checks++;
            if (obs_d0[i] !== ref_enc(exp_q[i], 1'b0) || obs_d1[i] !== ref_enc(exp_q[i], 1'b1)) begin
                errors++;
                $display("FAIL rand_data[%0d]: got %h/%h expected %h/%h", i, obs_d0[i], obs_d1[i],
                         ref_enc(exp_q[i], 1'b0), ref_enc(exp_q[i], 1'b1));
            end
        end
        checks++;
        if (stab_err !== 0 || bus_err !== 0 || sync_err !== 0) begin
            errors++;
            $display("FAIL rand_protocol: stab=%0d bus=%0d sync=%0d expected 0 0 0", stab_err, bus_err,
                     sync_err);
        end
        checks++;
        if (cnt0 !== 16'(exp_count)) begin
            errors++;
            $display("FAIL rand_count: got %0d expected %0d", cnt0, exp_count);
        end
        clear_obs();
    endtask

    initial begin
        test_reset();
        test_reset_mid_write();
        test_single();
        test_skip();
        test_waitreq();
        test_back_to_back();
        test_active_low();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
